// File: rtl/ServiceProtocol.sv
// Shared service-protocol types: command codes and the packet descriptor
// handed from the packet buffer to the command executor.
package ServiceProtocol;

  typedef enum logic [7:0] {
    CMD_NOP    = 8'h00,
    CMD_READ   = 8'h01,
    CMD_WRITE  = 8'h02,
    CMD_STATUS = 8'h03
  } TCommandCode;

  typedef struct packed {
    TCommandCode cmd;
    logic [7:0]  addr;
    logic [7:0]  size;
  } TSpDescriptor;

  localparam int unsigned MAX_PKT_WORDS = 255;

endpackage

// File: rtl/sp_desc_fifo.sv
// Small synchronous FIFO holding committed packet descriptors; a push while
// full is accepted only together with a pop, and a pop while empty is ignored.
module sp_desc_fifo #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] store_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = store_q[rd_ptr_q[AW-1:0]];

  // NOTE: storage has no reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) store_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/sp_packet_buffer.sv
// Speculative packet buffer: payload is written ahead of wr_ptr and only becomes
// readable when the packet commits; errors and overflows roll spec_ptr back.
module sp_packet_buffer
  import ServiceProtocol::*;
#(
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned DESC_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_request,
  input  logic [15:0] in_data,
  output logic        in_done,
  input  logic        packet_start,
  input  logic        packet_end,
  input  logic        packet_err,
  input  logic [7:0]  module_addr,
  input  TCommandCode cmd_code,
  output logic        desc_valid,
  output TCommandCode desc_cmd,
  output logic [7:0]  desc_addr,
  output logic [7:0]  desc_size,
  input  logic        desc_pop,
  input  logic        rd_request,
  output logic [15:0] rd_data,
  output logic        rd_empty,
  output logic        drop_pulse,
  output logic [7:0]  drop_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [PW-1:0] FULL_LEVEL = PW'(DEPTH);

  typedef enum logic [1:0] {IDLE, COLLECT, DROP} state_e;

  state_e          state_q, state_d, cur_state;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, spec_ptr_q, spec_ptr_d, rd_ptr_q, cur_spec;
  logic [7:0]      word_cnt_q, word_cnt_d, cur_cnt;
  logic [15:0]     mem [DEPTH];
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic            commit, drop, can_commit;
  logic            in_done_q, drop_pulse_q;
  logic [15:0]     rd_data_q;
  logic [7:0]      drop_count_q;
  logic            desc_full, desc_empty;
  TSpDescriptor    push_desc, head_desc;
  logic [$bits(TSpDescriptor)-1:0] head_bits;

  assign rd_empty   = (rd_ptr_q == wr_ptr_q);
  assign can_commit = !desc_full || desc_pop;

  // Events are applied in order: restart, word, then end/err, so a word
  // arriving with packet_end is part of the committed packet.
  // NOTE: every variable gets a default first so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    spec_ptr_d = spec_ptr_q;
    word_cnt_d = word_cnt_q;
    cur_state  = state_q;
    cur_spec   = spec_ptr_q;
    cur_cnt    = word_cnt_q;
    mem_we     = 1'b0;
    mem_waddr  = spec_ptr_q[AW-1:0];
    commit     = 1'b0;
    drop       = 1'b0;

    if (packet_start) begin
      drop      = (state_q != IDLE);
      cur_state = COLLECT;
      cur_spec  = wr_ptr_q;
      cur_cnt   = '0;
    end else if (state_q == IDLE) begin
      cur_cnt = '0;
    end

    if (in_request && cur_state == COLLECT) begin
      if ((cur_spec - rd_ptr_q) == FULL_LEVEL || cur_cnt == 8'(MAX_PKT_WORDS)) begin
        cur_state = DROP;
      end else begin
        mem_we    = 1'b1;
        mem_waddr = cur_spec[AW-1:0];
        cur_spec  = cur_spec + 1'b1;
        cur_cnt   = cur_cnt + 8'd1;
      end
    end

    state_d    = cur_state;
    spec_ptr_d = cur_spec;
    word_cnt_d = cur_cnt;

    if (packet_err || (packet_end && (cur_state == DROP || !can_commit))) begin
      drop       = 1'b1;
      state_d    = IDLE;
      spec_ptr_d = wr_ptr_q;
      word_cnt_d = '0;
    end else if (packet_end) begin
      commit     = 1'b1;
      wr_ptr_d   = cur_spec;
      state_d    = IDLE;
      word_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      spec_ptr_q   <= '0;
      rd_ptr_q     <= '0;
      word_cnt_q   <= '0;
      in_done_q    <= 1'b0;
      rd_data_q    <= '0;
      drop_pulse_q <= 1'b0;
      drop_count_q <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      spec_ptr_q   <= spec_ptr_d;
      word_cnt_q   <= word_cnt_d;
      in_done_q    <= in_request;
      drop_pulse_q <= drop;
      if (drop && drop_count_q != 8'hFF) drop_count_q <= drop_count_q + 8'd1;
      if (rd_request && !rd_empty) begin
        rd_data_q <= mem[rd_ptr_q[AW-1:0]];
        rd_ptr_q  <= rd_ptr_q + 1'b1;
      end
    end
  end

  assign push_desc = '{cmd: cmd_code, addr: module_addr, size: cur_cnt};

  sp_desc_fifo #(
    .WIDTH ($bits(TSpDescriptor)),
    .DEPTH (DESC_DEPTH)
  ) u_desc_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (commit),
    .data_i  (push_desc),
    .pop_i   (desc_pop),
    .data_o  (head_bits),
    .full_o  (desc_full),
    .empty_o (desc_empty)
  );

  assign head_desc  = TSpDescriptor'(head_bits);
  assign desc_valid = !desc_empty;
  assign desc_cmd   = head_desc.cmd;
  assign desc_addr  = head_desc.addr;
  assign desc_size  = head_desc.size;
  assign in_done    = in_done_q;
  assign rd_data    = rd_data_q;
  assign drop_pulse = drop_pulse_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_sp_packet_buffer.sv
// Bench for sp_packet_buffer: a directed vector table, hand-written corner
// sequences, and a random run against a queue-based packet model.
module tb_sp_packet_buffer;
  import ServiceProtocol::*;

  localparam int DEPTH      = 256;
  localparam int DESC_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st, rq, en, er, pop, rd;
  logic [15:0] din;
  logic [7:0]  addr;
  TCommandCode cmd;

  logic        in_done, desc_valid, rd_empty, drop_pulse;
  TCommandCode desc_cmd;
  logic [7:0]  desc_addr, desc_size, drop_count;
  logic [15:0] rd_data;

  int checks   = 0;
  int failures = 0;
  bit use_model;

  always #5 clk = ~clk;

  sp_packet_buffer #(.DEPTH(DEPTH), .DESC_DEPTH(DESC_DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_request   (rq),
    .in_data      (din),
    .in_done      (in_done),
    .packet_start (st),
    .packet_end   (en),
    .packet_err   (er),
    .module_addr  (addr),
    .cmd_code     (cmd),
    .desc_valid   (desc_valid),
    .desc_cmd     (desc_cmd),
    .desc_addr    (desc_addr),
    .desc_size    (desc_size),
    .desc_pop     (pop),
    .rd_request   (rd),
    .rd_data      (rd_data),
    .rd_empty     (rd_empty),
    .drop_pulse   (drop_pulse),
    .drop_count   (drop_count)
  );

  // Reference model: committed words and descriptors as queues, the open
  // packet as a word list; mode 0 = no packet, 1 = collecting, 2 = dropping.
  logic [15:0]  m_words[$];
  logic [15:0]  m_pkt[$];
  TSpDescriptor m_desc[$];
  int           m_mode, m_drop_cnt;
  logic [15:0]  m_rd_data;
  bit           m_done, m_drop_pulse;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    st = 0; rq = 0; en = 0; er = 0; pop = 0; rd = 0;
    din = '0; addr = '0; cmd = CMD_NOP;
  endtask

  task automatic model_reset();
    m_words.delete(); m_pkt.delete(); m_desc.delete();
    m_mode = 0; m_drop_cnt = 0; m_rd_data = '0; m_done = 0; m_drop_pulse = 0;
  endtask

  task automatic model_step();
    int pre_words = m_words.size();
    int pre_desc  = m_desc.size();
    bit drop      = 0;
    m_done = rq;
    if (rd && pre_words > 0) m_rd_data = m_words.pop_front();
    if (st) begin
      if (m_mode != 0) drop = 1;
      m_mode = 1;
      m_pkt.delete();
    end
    if (rq && m_mode == 1) begin
      if (pre_words + m_pkt.size() == DEPTH || m_pkt.size() == 255) m_mode = 2;
      else m_pkt.push_back(din);
    end
    if (er) begin
      drop = 1; m_mode = 0; m_pkt.delete();
    end else if (en) begin
      if (m_mode == 2 || (pre_desc == DESC_DEPTH && !pop)) drop = 1;
      else begin
        foreach (m_pkt[i]) m_words.push_back(m_pkt[i]);
        m_desc.push_back('{cmd: cmd, addr: addr, size: 8'(m_pkt.size())});
      end
      m_mode = 0; m_pkt.delete();
    end
    if (pop && pre_desc > 0) m_desc.delete(0);
    m_drop_pulse = drop;
    if (drop && m_drop_cnt < 255) m_drop_cnt++;
  endtask

  task automatic compare_model();
    check("m_in_done", in_done, m_done);
    check("m_drop_pulse", drop_pulse, m_drop_pulse);
    check("m_drop_count", drop_count, m_drop_cnt);
    check("m_rd_empty", rd_empty, m_words.size() == 0);
    check("m_desc_valid", desc_valid, m_desc.size() != 0);
    if (m_desc.size() != 0) begin
      check("m_desc_cmd", desc_cmd, m_desc[0].cmd);
      check("m_desc_addr", desc_addr, m_desc[0].addr);
      check("m_desc_size", desc_size, m_desc[0].size);
    end
    check("m_rd_data", rd_data, m_rd_data);
  endtask

  task automatic tick();
    @(posedge clk);
    if (use_model) model_step();
    #1;
    if (use_model) compare_model();
    st = 0; rq = 0; en = 0; er = 0; pop = 0; rd = 0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_done"}, in_done, 0);
    check({tag, "_desc_valid"}, desc_valid, 0);
    check({tag, "_rd_empty"}, rd_empty, 1);
    check({tag, "_rd_data"}, rd_data, 0);
    check({tag, "_drop_pulse"}, drop_pulse, 0);
    check({tag, "_drop_count"}, drop_count, 0);
  endtask

  task automatic do_reset();
    rst_n = 0;
    clear_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst_n = 1;
  endtask

  task automatic send_pkt(input int n, input int base, input logic [7:0] a, input TCommandCode c);
    for (int i = 0; i < n; i++) begin
      st = (i == 0); rq = 1; din = 16'(base + i);
      tick();
    end
    en = 1; addr = a; cmd = c;
    tick();
  endtask

  task automatic read_words(input int n);
    for (int i = 0; i < n; i++) begin
      rd = 1;
      tick();
    end
  endtask

  typedef struct {
    logic st, rq; logic [15:0] d; logic en, er; logic [7:0] a; TCommandCode c;
    logic pop, rd;
    logic e_dv; TCommandCode e_cmd; logic [7:0] e_addr, e_size;
    logic e_rde; logic [15:0] e_rd; logic e_drop; logic [7:0] e_cnt;
  } vec_t;

  function automatic vec_t v(input logic st_, rq_, input logic [15:0] d_, input logic en_, er_,
                             input logic [7:0] a_, input TCommandCode c_, input logic pop_, rd_,
                             input logic e_dv, input TCommandCode e_cmd, input logic [7:0] e_addr,
                             input logic [7:0] e_size, input logic e_rde, input logic [15:0] e_rd,
                             input logic e_drop, input logic [7:0] e_cnt);
    vec_t r;
    r = '{st_, rq_, d_, en_, er_, a_, c_, pop_, rd_, e_dv, e_cmd, e_addr, e_size, e_rde, e_rd, e_drop, e_cnt};
    return r;
  endfunction

  vec_t vecs[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    TCommandCode cmds[4];
    cmds[0] = CMD_NOP; cmds[1] = CMD_READ; cmds[2] = CMD_WRITE; cmds[3] = CMD_STATUS;
    use_model = 0;

    //          st rq data     en er addr  cmd        pop rd | dv cmd        addr  size rde rd_data  drop cnt
    vecs.push_back(v(1, 1, 16'h1111, 0, 0, 8'h00, CMD_NOP,   0, 0, 0, CMD_NOP,   8'h00, 0, 1, 16'h0000, 0, 0));
    vecs.push_back(v(0, 1, 16'h2222, 0, 0, 8'h00, CMD_NOP,   0, 0, 0, CMD_NOP,   8'h00, 0, 1, 16'h0000, 0, 0));
    vecs.push_back(v(0, 1, 16'h3333, 0, 0, 8'h00, CMD_NOP,   0, 0, 0, CMD_NOP,   8'h00, 0, 1, 16'h0000, 0, 0));
    vecs.push_back(v(0, 0, 16'h0000, 1, 0, 8'h05, CMD_READ,  0, 0, 1, CMD_READ,  8'h05, 3, 0, 16'h0000, 0, 0));
    vecs.push_back(v(0, 0, 16'h0000, 0, 0, 8'h00, CMD_NOP,   1, 0, 0, CMD_NOP,   8'h00, 0, 0, 16'h0000, 0, 0));
    vecs.push_back(v(0, 0, 16'h0000, 0, 0, 8'h00, CMD_NOP,   0, 1, 0, CMD_NOP,   8'h00, 0, 0, 16'h1111, 0, 0));
    vecs.push_back(v(0, 0, 16'h0000, 0, 0, 8'h00, CMD_NOP,   0, 1, 0, CMD_NOP,   8'h00, 0, 0, 16'h2222, 0, 0));
    vecs.push_back(v(0, 0, 16'h0000, 0, 0, 8'h00, CMD_NOP,   0, 1, 0, CMD_NOP,   8'h00, 0, 1, 16'h3333, 0, 0));
    vecs.push_back(v(0, 0, 16'h0000, 0, 0, 8'h00, CMD_NOP,   0, 1, 0, CMD_NOP,   8'h00, 0, 1, 16'h3333, 0, 0));
    vecs.push_back(v(1, 1, 16'hAAAA, 0, 0, 8'h00, CMD_NOP,   0, 0, 0, CMD_NOP,   8'h00, 0, 1, 16'h3333, 0, 0));
    vecs.push_back(v(0, 1, 16'hBBBB, 0, 0, 8'h00, CMD_NOP,   0, 0, 0, CMD_NOP,   8'h00, 0, 1, 16'h3333, 0, 0));
    vecs.push_back(v(0, 0, 16'h0000, 0, 1, 8'h07, CMD_WRITE, 0, 0, 0, CMD_NOP,   8'h00, 0, 1, 16'h3333, 1, 1));
    vecs.push_back(v(0, 0, 16'h0000, 0, 0, 8'h00, CMD_NOP,   0, 0, 0, CMD_NOP,   8'h00, 0, 1, 16'h3333, 0, 1));
    vecs.push_back(v(1, 1, 16'hABCD, 0, 0, 8'h00, CMD_NOP,   0, 0, 0, CMD_NOP,   8'h00, 0, 1, 16'h3333, 0, 1));
    vecs.push_back(v(0, 0, 16'h0000, 1, 0, 8'h10, CMD_WRITE, 0, 0, 1, CMD_WRITE, 8'h10, 1, 0, 16'h3333, 0, 1));
    vecs.push_back(v(0, 0, 16'h0000, 0, 0, 8'h00, CMD_NOP,   1, 0, 0, CMD_NOP,   8'h00, 0, 0, 16'h3333, 0, 1));
    vecs.push_back(v(0, 0, 16'h0000, 0, 0, 8'h00, CMD_NOP,   0, 1, 0, CMD_NOP,   8'h00, 0, 1, 16'hABCD, 0, 1));
    vecs.push_back(v(0, 0, 16'h0000, 1, 0, 8'h22, CMD_READ,  0, 0, 1, CMD_READ,  8'h22, 0, 1, 16'hABCD, 0, 1));
    vecs.push_back(v(0, 0, 16'h0000, 0, 0, 8'h00, CMD_NOP,   1, 0, 0, CMD_NOP,   8'h00, 0, 1, 16'hABCD, 0, 1));
    vecs.push_back(v(1, 1, 16'h1234, 0, 0, 8'h00, CMD_NOP,   0, 0, 0, CMD_NOP,   8'h00, 0, 1, 16'hABCD, 0, 1));
    vecs.push_back(v(0, 1, 16'h5678, 1, 0, 8'h33, CMD_WRITE, 0, 0, 1, CMD_WRITE, 8'h33, 2, 0, 16'hABCD, 0, 1));
    vecs.push_back(v(0, 0, 16'h0000, 0, 0, 8'h00, CMD_NOP,   1, 0, 0, CMD_NOP,   8'h00, 0, 0, 16'hABCD, 0, 1));
    vecs.push_back(v(0, 0, 16'h0000, 0, 0, 8'h00, CMD_NOP,   0, 1, 0, CMD_NOP,   8'h00, 0, 0, 16'h1234, 0, 1));
    vecs.push_back(v(0, 0, 16'h0000, 0, 0, 8'h00, CMD_NOP,   0, 1, 0, CMD_NOP,   8'h00, 0, 1, 16'h5678, 0, 1));
    vecs.push_back(v(1, 1, 16'h9999, 0, 0, 8'h00, CMD_NOP,   0, 0, 0, CMD_NOP,   8'h00, 0, 1, 16'h5678, 0, 1));
    vecs.push_back(v(0, 0, 16'h0000, 1, 1, 8'h44, CMD_READ,  0, 0, 0, CMD_NOP,   8'h00, 0, 1, 16'h5678, 1, 2));
    vecs.push_back(v(0, 0, 16'h0000, 0, 0, 8'h00, CMD_NOP,   1, 1, 0, CMD_NOP,   8'h00, 0, 1, 16'h5678, 0, 2));

    do_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      st = vecs[i].st; rq = vecs[i].rq; din = vecs[i].d; en = vecs[i].en; er = vecs[i].er;
      addr = vecs[i].a; cmd = vecs[i].c; pop = vecs[i].pop; rd = vecs[i].rd;
      tick();
      check($sformatf("vec%0d_in_done", i), in_done, vecs[i].rq);
      check($sformatf("vec%0d_desc_valid", i), desc_valid, vecs[i].e_dv);
      if (vecs[i].e_dv) begin
        check($sformatf("vec%0d_desc_cmd", i), desc_cmd, vecs[i].e_cmd);
        check($sformatf("vec%0d_desc_addr", i), desc_addr, vecs[i].e_addr);
        check($sformatf("vec%0d_desc_size", i), desc_size, vecs[i].e_size);
      end
      check($sformatf("vec%0d_rd_empty", i), rd_empty, vecs[i].e_rde);
      check($sformatf("vec%0d_rd_data", i), rd_data, vecs[i].e_rd);
      check($sformatf("vec%0d_drop_pulse", i), drop_pulse, vecs[i].e_drop);
      check($sformatf("vec%0d_drop_count", i), drop_count, vecs[i].e_cnt);
    end

    // Buffer overflow: 200 committed words leave room for only 56 more.
    use_model = 1;
    do_reset();
    send_pkt(200, 'h1000, 8'h01, CMD_WRITE);
    check("ovf_first_size", desc_size, 200);
    send_pkt(100, 'h2000, 8'h02, CMD_READ);
    check("ovf_drop_pulse", drop_pulse, 1);
    check("ovf_drop_count", drop_count, 1);
    pop = 1; tick();
    read_words(200);
    check("ovf_last_word", rd_data, 16'h1000 + 16'd199);
    check("ovf_rd_empty", rd_empty, 1);

    // Packet length limit: 255 words commit, 256 words are dropped.
    do_reset();
    send_pkt(255, 'h5000, 8'h03, CMD_WRITE);
    check("len255_size", desc_size, 255);
    check("len255_no_drop", drop_count, 0);
    pop = 1; tick();
    read_words(255);
    send_pkt(256, 'h6000, 8'h04, CMD_WRITE);
    check("len256_drop_count", drop_count, 1);
    check("len256_rd_empty", rd_empty, 1);

    // Descriptor queue full, then a pop coinciding with packet_end.
    do_reset();
    for (int i = 0; i < 4; i++) send_pkt(1, 'h7000 + i, 8'(i), CMD_READ);
    send_pkt(1, 'h7004, 8'h04, CMD_READ);
    check("dfull_drop_pulse", drop_pulse, 1);
    check("dfull_drop_count", drop_count, 1);
    st = 1; rq = 1; din = 16'h7005; tick();
    en = 1; pop = 1; addr = 8'h05; cmd = CMD_WRITE; tick();
    check("dpop_no_drop", drop_pulse, 0);
    check("dpop_drop_count", drop_count, 1);
    check("dpop_desc_valid", desc_valid, 1);

    // Asynchronous reset in the middle of a packet.
    do_reset();
    send_pkt(2, 'h3000, 8'h11, CMD_READ);
    send_pkt(3, 'h3100, 8'h12, CMD_WRITE);
    st = 1; rq = 1; din = 16'h3200; tick();
    er = 1; tick();
    rd = 1; tick();
    st = 1; rq = 1; din = 16'h3300; tick();
    rq = 1; din = 16'h3301; tick();
    check("pre_rst_drop_count", drop_count, 1);
    check("pre_rst_rd_data", rd_data, 16'h3000);
    #3 rst_n = 0;
    #1;
    check_reset_values("async_rst");
    @(posedge clk); #1;
    model_reset();
    rst_n = 1;
    send_pkt(2, 'h4000, 8'h21, CMD_STATUS);
    check("post_rst_desc_size", desc_size, 2);
    pop = 1; tick();
    read_words(2);
    check("post_rst_rd_data", rd_data, 16'h4001);

    // Random traffic against the model; reads are sparse early so the buffer fills.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      int r;
      st   = ($urandom_range(0, 99) < 5);
      rq   = st || ($urandom_range(0, 99) < 60);
      din  = 16'($urandom);
      r    = $urandom_range(0, 99);
      en   = !st && (r < 6);
      er   = !st && (r >= 6) && (r < 8);
      addr = 8'($urandom);
      cmd  = cmds[$urandom_range(0, 3)];
      pop  = ($urandom_range(0, 99) < 20);
      rd   = ($urandom_range(0, 99) < ((n < 1500) ? 10 : 45));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
